// File: rtl/rtc_multi_alarm_core_pkg.sv
// Shared types, field limits and range helper for the multi-alarm RTC core.
package rtc_pkg;

    localparam int HH_W = 5;
    localparam int MS_W = 6;

    localparam logic [HH_W-1:0] HH_MAX = 5'd23;
    localparam logic [MS_W-1:0] MM_MAX = 6'd59;
    localparam logic [MS_W-1:0] SS_MAX = 6'd59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } rtc_state_e;

    // Seconds are only meaningful for time loads; alarm loads pass check_s = 0.
    function automatic logic time_in_range(input logic [HH_W-1:0] h,
                                           input logic [MS_W-1:0] m,
                                           input logic [MS_W-1:0] s,
                                           input logic            check_s);
        return (h <= HH_MAX) && (m <= MM_MAX) && (!check_s || (s <= SS_MAX));
    endfunction

endpackage

// File: rtl/rtc_multi_alarm_core_if.sv
// Load bus for time and alarm registers, with the reject pulse returned to the loader.
interface rtc_multi_alarm_core_if #(parameter int N_ALARMS = 4);
    import rtc_pkg::*;

    localparam int IDX_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

    logic             set_valid;
    logic             set_sel;
    logic [IDX_W-1:0] set_idx;
    logic [HH_W-1:0]  set_hh;
    logic [MS_W-1:0]  set_mm;
    logic [MS_W-1:0]  set_ss;
    logic             set_err;

    modport master (output set_valid, set_sel, set_idx, set_hh, set_mm, set_ss,
                    input  set_err);
    modport slave  (input  set_valid, set_sel, set_idx, set_hh, set_mm, set_ss,
                    output set_err);
endinterface

// File: rtl/rtc_multi_alarm_core_prescaler.sv
// Divides clk down to a one-second tick and a half-second blink phase.
module rtc_prescaler #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic sec_tick,
    output logic blink
);
    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] HALF = PW'(TICKS_PER_SEC / 2);

    logic [PW-1:0] cnt_r;

    // Free-running divider, frozen when run is low and zeroed by a time load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {PW{1'b0}};
        end else if (clear) begin
            cnt_r <= {PW{1'b0}};
        end else if (run && (cnt_r == LAST)) begin
            cnt_r <= {PW{1'b0}};
        end else if (run) begin
            cnt_r <= cnt_r + PW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sec_tick = run && (cnt_r == LAST);
    assign blink    = run && (cnt_r >= HALF);

endmodule

// File: rtl/rtc_multi_alarm_core.sv
// 24-hour time-of-day counter with N alarm channels and a ring/snooze/ack controller.
module rtc_multi_alarm_core
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC  = 50_000_000,
    parameter int N_ALARMS       = 4,
    parameter int SNOOZE_S       = 300,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    rtc_multi_alarm_core_if.slave      set_bus,
    input  logic [N_ALARMS-1:0]        alarm_en,
    input  logic                       ack,
    input  logic                       snooze,
    output logic [HH_W-1:0]            hh,
    output logic [MS_W-1:0]            mm,
    output logic [MS_W-1:0]            ss,
    output logic                       tick_1hz,
    output logic                       blink,
    output logic                       ringing,
    output logic [N_ALARMS-1:0]        ring_mask,
    output logic [HH_W*N_ALARMS-1:0]   alarm_hh,
    output logic [MS_W*N_ALARMS-1:0]   alarm_mm
);
    localparam int CNT_MAX = (SNOOZE_S > RING_TIMEOUT_S) ? SNOOZE_S : RING_TIMEOUT_S;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RING_LAST = CW'(RING_TIMEOUT_S - 1);
    localparam logic [CW-1:0] SNZ_LAST  = CW'(SNOOZE_S - 1);
    localparam logic [3:0]    IDX_LIM   = 4'(N_ALARMS);

    logic [HH_W-1:0] hh_r, hh_nx_s;
    logic [MS_W-1:0] mm_r, mm_nx_s, ss_r, ss_nx_s;
    logic            tick_1hz_r, set_err_r, ringing_r, ringing_nx_s;
    logic            sec_tick_s, load_ok_s, time_load_s, alarm_load_s, adv_s;
    logic [3:0]      idx_s;
    logic [N_ALARMS-1:0] match_s, mask_live_s, ring_mask_r, mask_nx_s;
    logic [CW-1:0]   cnt_r, cnt_nx_s;
    rtc_state_e      state_r, state_nx_s;

    rtc_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .clear    (time_load_s),
        .sec_tick (sec_tick_s),
        .blink    (blink)
    );

    assign idx_s = 4'(set_bus.set_idx);

    // Load validation: alarm loads skip seconds but must address an existing channel.
    always_comb begin
        load_ok_s = 1'b0;
        if (set_bus.set_valid && set_bus.set_sel) begin
            load_ok_s = time_in_range(set_bus.set_hh, set_bus.set_mm, set_bus.set_ss, 1'b0)
                        && (idx_s < IDX_LIM);
        end else if (set_bus.set_valid) begin
            load_ok_s = time_in_range(set_bus.set_hh, set_bus.set_mm, set_bus.set_ss, 1'b1);
        end else begin
            load_ok_s = 1'b0;
        end
    end

    assign time_load_s  = load_ok_s && !set_bus.set_sel;
    assign alarm_load_s = load_ok_s &&  set_bus.set_sel;
    // A time load overrides a coincident tick, so the second never advances then.
    assign adv_s        = sec_tick_s && !time_load_s;

    // Next time of day: load, carry-chain advance, or hold.
    always_comb begin
        hh_nx_s = hh_r;
        mm_nx_s = mm_r;
        ss_nx_s = ss_r;
        if (time_load_s) begin
            hh_nx_s = set_bus.set_hh;
            mm_nx_s = set_bus.set_mm;
            ss_nx_s = set_bus.set_ss;
        end else if (adv_s && (ss_r == SS_MAX)) begin
            ss_nx_s = 6'd0;
            if (mm_r == MM_MAX) begin
                mm_nx_s = 6'd0;
                hh_nx_s = (hh_r == HH_MAX) ? 5'd0 : (hh_r + 5'd1);
            end else begin
                mm_nx_s = mm_r + 6'd1;
            end
        end else if (adv_s) begin
            ss_nx_s = ss_r + 6'd1;
        end else begin
            ss_nx_s = ss_r;
        end
    end

    // Time registers plus the registered tick and reject pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            hh_r       <= 5'd0;
            mm_r       <= 6'd0;
            ss_r       <= 6'd0;
            tick_1hz_r <= 1'b0;
            set_err_r  <= 1'b0;
        end else begin
            hh_r       <= hh_nx_s;
            mm_r       <= mm_nx_s;
            ss_r       <= ss_nx_s;
            tick_1hz_r <= adv_s;
            set_err_r  <= set_bus.set_valid && !load_ok_s;
        end
    end

    for (genvar i = 0; i < N_ALARMS; i++) begin : g_alarm
        logic [HH_W-1:0] a_hh_r;
        logic [MS_W-1:0] a_mm_r;

        // Per-channel alarm time, written only by an accepted load addressed to it.
        always_ff @(posedge clk) begin
            if (rst) begin
                a_hh_r <= 5'd0;
                a_mm_r <= 6'd0;
            end else if (alarm_load_s && (idx_s == 4'(i))) begin
                a_hh_r <= set_bus.set_hh;
                a_mm_r <= set_bus.set_mm;
            end else begin
                a_hh_r <= a_hh_r;
                a_mm_r <= a_mm_r;
            end
        end

        assign match_s[i] = adv_s && alarm_en[i] && (ss_nx_s == 6'd0)
                            && (hh_nx_s == a_hh_r) && (mm_nx_s == a_mm_r);
        assign alarm_hh[i*HH_W +: HH_W] = a_hh_r;
        assign alarm_mm[i*MS_W +: MS_W] = a_mm_r;
    end

    assign mask_live_s = ring_mask_r & alarm_en;

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ring_mask_r <= {N_ALARMS{1'b0}};
            cnt_r       <= {CW{1'b0}};
            ringing_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            ring_mask_r <= mask_nx_s;
            cnt_r       <= cnt_nx_s;
            ringing_r   <= ringing_nx_s;
        end
    end

    // Controller next state; everything freezes while the clock is in edit mode.
    always_comb begin
        state_nx_s = state_r;
        mask_nx_s  = ring_mask_r;
        cnt_nx_s   = cnt_r;
        if (!run) begin
            state_nx_s = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|match_s) begin
                        state_nx_s = RING;
                        mask_nx_s  = match_s;
                        cnt_nx_s   = {CW{1'b0}};
                    end else begin
                        mask_nx_s  = {N_ALARMS{1'b0}};
                    end
                end
                RING: begin
                    mask_nx_s = mask_live_s | match_s;
                    if (ack) begin
                        state_nx_s = IDLE;
                        mask_nx_s  = {N_ALARMS{1'b0}};
                        cnt_nx_s   = {CW{1'b0}};
                    end else if (snooze || (|match_s)) begin
                        state_nx_s = snooze ? SNOOZE : RING;
                        cnt_nx_s   = {CW{1'b0}};
                    end else if ((mask_live_s == {N_ALARMS{1'b0}}) || (adv_s && (cnt_r == RING_LAST))) begin
                        state_nx_s = IDLE;
                        mask_nx_s  = {N_ALARMS{1'b0}};
                        cnt_nx_s   = {CW{1'b0}};
                    end else if (adv_s) begin
                        cnt_nx_s   = cnt_r + CW'(1);
                    end else begin
                        cnt_nx_s   = cnt_r;
                    end
                end
                SNOOZE: begin
                    mask_nx_s = mask_live_s | match_s;
                    if (ack || (mask_live_s == {N_ALARMS{1'b0}} && !(|match_s))) begin
                        state_nx_s = IDLE;
                        mask_nx_s  = {N_ALARMS{1'b0}};
                        cnt_nx_s   = {CW{1'b0}};
                    end else if ((|match_s) || (adv_s && (cnt_r == SNZ_LAST))) begin
                        state_nx_s = RING;
                        cnt_nx_s   = {CW{1'b0}};
                    end else if (adv_s) begin
                        cnt_nx_s   = cnt_r + CW'(1);
                    end else begin
                        cnt_nx_s   = cnt_r;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    mask_nx_s  = {N_ALARMS{1'b0}};
                    cnt_nx_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Controller outputs, decoded from the next state so the buzzer enable is a flop.
    always_comb begin
        ringing_nx_s = (state_nx_s == RING);
    end

    assign hh              = hh_r;
    assign mm              = mm_r;
    assign ss              = ss_r;
    assign tick_1hz        = tick_1hz_r;
    assign ringing         = ringing_r;
    assign ring_mask       = ring_mask_r;
    assign set_bus.set_err = set_err_r;

endmodule

// File: tb/tb_rtc_multi_alarm_core.sv
// Directed scoreboard bench for rtc_multi_alarm_core with a fast prescaler and short timers.
module tb_rtc_multi_alarm_core;
    localparam int K_TIME = 0, K_RING = 1, K_MASK = 2, K_TICK = 3, K_BLINK = 4,
                   K_ERR = 5, K_AHH = 6, K_AMM = 7;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic clk = 1'b0;
    logic rst, run, ack, snooze;
    logic [3:0]  alarm_en;
    logic [4:0]  hh;
    logic [5:0]  mm, ss;
    logic        tick_1hz, blink, ringing;
    logic [3:0]  ring_mask;
    logic [19:0] alarm_hh;
    logic [23:0] alarm_mm;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit drain_req = 1'b0;
    chk_t        chk_q[$];
    logic [31:0] tick_q[$];

    rtc_multi_alarm_core_if #(.N_ALARMS(4)) sbus ();

    rtc_multi_alarm_core #(
        .TICKS_PER_SEC(4), .N_ALARMS(4), .SNOOZE_S(3), .RING_TIMEOUT_S(5)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .set_bus(sbus), .alarm_en(alarm_en),
        .ack(ack), .snooze(snooze), .hh(hh), .mm(mm), .ss(ss),
        .tick_1hz(tick_1hz), .blink(blink), .ringing(ringing),
        .ring_mask(ring_mask), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] tv(input int h, input int m, input int s);
        return {15'd0, 5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [31:0] sample(input int kind);
        case (kind)
            K_TIME:  return {15'd0, hh, mm, ss};
            K_RING:  return {31'd0, ringing};
            K_MASK:  return {28'd0, ring_mask};
            K_TICK:  return {31'd0, tick_1hz};
            K_BLINK: return {31'd0, blink};
            K_ERR:   return {31'd0, sbus.set_err};
            K_AHH:   return {12'd0, alarm_hh};
            K_AMM:   return {8'd0, alarm_mm};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: scheduled status checks, plus time checks popped on every tick_1hz pulse.
    always @(negedge clk) begin
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (drain_req || chk_q[i].cyc <= cyc) begin
                logic [31:0] act;
                act = sample(chk_q[i].kind);
                n_checks++;
                if (drain_req || chk_q[i].cyc < cyc || act !== chk_q[i].exp) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d (due %0d): got 0x%0h, expected 0x%0h",
                             chk_q[i].name, cyc, chk_q[i].cyc, act, chk_q[i].exp);
                end
                chk_q.delete(i);
            end
        end
        if (tick_1hz && tick_q.size() > 0) begin
            logic [31:0] e;
            e = tick_q.pop_front();
            n_checks++;
            if (sample(K_TIME) !== e) begin
                n_fail++;
                $display("FAIL tick_time @cyc %0d: got 0x%0h, expected 0x%0h", cyc, sample(K_TIME), e);
            end
        end
        if (drain_req && tick_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_missing: got %0d unconsumed, expected 0", tick_q.size());
            tick_q.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input int kind, input logic [31:0] v, input string nm);
        chk_t t;
        t.cyc = c; t.kind = kind; t.exp = v; t.name = nm;
        chk_q.push_back(t);
    endtask

    task automatic load(input logic sel, input logic [1:0] idx, input int h, input int m, input int s);
        sbus.set_valid = 1'b1; sbus.set_sel = sel; sbus.set_idx = idx;
        sbus.set_hh = 5'(h); sbus.set_mm = 6'(m); sbus.set_ss = 6'(s);
        step();
        sbus.set_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        logic [3:0] bl_tab;
        rst = 1'b1; run = 1'b0; ack = 1'b0; snooze = 1'b0; alarm_en = 4'b0000;
        sbus.set_valid = 1'b0; sbus.set_sel = 1'b0; sbus.set_idx = 2'd0;
        sbus.set_hh = 5'd0; sbus.set_mm = 6'd0; sbus.set_ss = 6'd0;
        repeat (3) step();
        rst = 1'b0;
        b = cyc;
        expect_at(b, K_TIME, tv(0, 0, 0), "rst_time");
        expect_at(b, K_RING, 32'd0, "rst_ring");
        expect_at(b, K_MASK, 32'd0, "rst_mask");
        expect_at(b, K_TICK, 32'd0, "rst_tick");
        expect_at(b, K_ERR,  32'd0, "rst_err");
        expect_at(b, K_AHH,  32'd0, "rst_ahh");

        // Rollover through midnight with a 4-cycle second.
        load(1'b0, 2'd0, 23, 59, 58);
        b = cyc;
        run = 1'b1;
        expect_at(b, K_TIME, tv(23, 59, 58), "t1_load");
        bl_tab = 4'b1100;
        for (int i = 0; i < 8; i++) expect_at(b + i, K_BLINK, {31'd0, bl_tab[i % 4]}, "t1_blink");
        expect_at(b + 3, K_TICK, 32'd0, "t1_tick_lo");
        expect_at(b + 4, K_TICK, 32'd1, "t1_tick_a");
        expect_at(b + 5, K_TICK, 32'd0, "t1_tick_pulse");
        expect_at(b + 8, K_TICK, 32'd1, "t1_tick_b");
        tick_q.push_back(tv(23, 59, 59));
        tick_q.push_back(tv(0, 0, 0));
        repeat (8) step();
        run = 1'b0;

        // Rejected loads leave everything untouched.
        b = cyc;
        expect_at(b + 1, K_ERR, 32'd1, "t2_err_hh");
        expect_at(b + 1, K_TIME, tv(0, 0, 0), "t2_time_kept");
        expect_at(b + 2, K_ERR, 32'd1, "t2_err_mm");
        expect_at(b + 2, K_AMM, 32'd0, "t2_amm_kept");
        expect_at(b + 2, K_AHH, 32'd0, "t2_ahh_kept");
        expect_at(b + 3, K_ERR, 32'd1, "t2_err_ss");
        expect_at(b + 4, K_ERR, 32'd0, "t2_err_clear");
        expect_at(b + 4, K_TIME, tv(0, 0, 0), "t2_time_final");
        load(1'b0, 2'd0, 24, 0, 0);
        load(1'b1, 2'd1, 5, 60, 0);
        load(1'b0, 2'd0, 12, 0, 60);
        step();

        // Two enabled alarms at 07:00 fire on the same tick.
        b = cyc;
        expect_at(b + 3, K_AHH, 32'h1D87, "t3_ahh_packed");
        expect_at(b + 3, K_AMM, 32'h0880, "t3_amm_packed");
        expect_at(b + 4, K_ERR, 32'd0, "t3_err_none");
        expect_at(b + 4, K_TIME, tv(6, 59, 59), "t3_time_load");
        load(1'b1, 2'd0, 7, 0, 0);
        load(1'b1, 2'd1, 12, 34, 0);
        load(1'b1, 2'd2, 7, 0, 0);
        load(1'b0, 2'd0, 6, 59, 59);
        b = cyc;
        alarm_en = 4'b0101;
        run = 1'b1;
        tick_q.push_back(tv(7, 0, 0));
        expect_at(b + 3, K_RING, 32'd0, "t3_ring_before");
        expect_at(b + 4, K_RING, 32'd1, "t3_ring");
        expect_at(b + 4, K_MASK, 32'd5, "t3_mask");
        // Snooze for three ticks, then ack beats a simultaneous snooze.
        expect_at(b + 6, K_RING, 32'd0, "t4_snooze_ring");
        expect_at(b + 6, K_MASK, 32'd5, "t4_snooze_mask");
        expect_at(b + 15, K_RING, 32'd0, "t4_snooze_hold");
        expect_at(b + 16, K_RING, 32'd1, "t4_rering");
        expect_at(b + 16, K_MASK, 32'd5, "t4_rering_mask");
        expect_at(b + 16, K_TIME, tv(7, 0, 3), "t4_time");
        expect_at(b + 17, K_RING, 32'd0, "t4_ack_ring");
        expect_at(b + 17, K_MASK, 32'd0, "t4_ack_mask");
        expect_at(b + 28, K_RING, 32'd0, "t4_stays_idle");
        repeat (5) step();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        repeat (10) step();
        ack = 1'b1; snooze = 1'b1;
        step();
        ack = 1'b0; snooze = 1'b0;
        repeat (12) step();

        // Ring timeout after five unanswered ticks.
        run = 1'b0;
        load(1'b0, 2'd0, 6, 59, 59);
        b = cyc;
        run = 1'b1;
        expect_at(b + 4, K_RING, 32'd1, "t5_ring");
        expect_at(b + 23, K_RING, 32'd1, "t5_before_timeout");
        expect_at(b + 24, K_RING, 32'd0, "t5_timeout_ring");
        expect_at(b + 24, K_MASK, 32'd0, "t5_timeout_mask");
        repeat (24) step();

        // Dropping enables trims the mask; an empty mask ends the ring.
        run = 1'b0;
        load(1'b0, 2'd0, 6, 59, 59);
        b = cyc;
        run = 1'b1;
        expect_at(b + 4, K_MASK, 32'd5, "t5b_mask");
        expect_at(b + 6, K_RING, 32'd1, "t5b_partial_ring");
        expect_at(b + 6, K_MASK, 32'd4, "t5b_partial_mask");
        expect_at(b + 7, K_RING, 32'd0, "t5b_empty_ring");
        expect_at(b + 7, K_MASK, 32'd0, "t5b_empty_mask");
        repeat (5) step();
        alarm_en = 4'b0100;
        step();
        alarm_en = 4'b0000;
        step();
        step();
        alarm_en = 4'b0101;

        // A time load on the tick cycle wins and never matches an alarm.
        run = 1'b0;
        load(1'b0, 2'd0, 10, 20, 30);
        b = cyc;
        run = 1'b1;
        expect_at(b + 3, K_TIME, tv(10, 20, 30), "t6_before");
        expect_at(b + 4, K_TIME, tv(7, 0, 0), "t6_load_wins");
        expect_at(b + 4, K_RING, 32'd0, "t6_load_no_match");
        expect_at(b + 8, K_TIME, tv(7, 0, 1), "t6_next_tick");
        expect_at(b + 8, K_RING, 32'd0, "t6_still_idle");
        repeat (3) step();
        load(1'b0, 2'd0, 7, 0, 0);
        repeat (4) step();

        // Reset while ringing.
        run = 1'b0;
        load(1'b0, 2'd0, 6, 59, 59);
        b = cyc;
        run = 1'b1;
        expect_at(b + 4, K_RING, 32'd1, "t6_rst_ring_pre");
        expect_at(b + 6, K_RING, 32'd0, "t6_rst_ring");
        expect_at(b + 6, K_MASK, 32'd0, "t6_rst_mask");
        expect_at(b + 6, K_TIME, tv(0, 0, 0), "t6_rst_time");
        expect_at(b + 6, K_AHH, 32'd0, "t6_rst_ahh");
        expect_at(b + 6, K_AMM, 32'd0, "t6_rst_amm");
        expect_at(b + 6, K_BLINK, 32'd0, "t6_rst_blink");
        expect_at(b + 6, K_TICK, 32'd0, "t6_rst_tick");
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run = 1'b0;
        repeat (2) step();

        drain_req = 1'b1;
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
